fifo_pop_stream: RTL and testbench
==================================

// Module: fifo_pop_stream
// PURPOSE
//  Read-side adapter for the 1-cycle-latency pop/valid FIFO interface: issues pops, captures returned data,
//  presents it as a ready/valid stream with back-pressure. Sits between the FIFO's pop/empty/rdata/valid pins
//  and any downstream consumer. Sustains one word/cycle when SKID >= RD_LAT+2; never overflows its buffer.
// PARAMETERS
//  WIDTH   16  data width, must match the FIFO
//  RD_LAT  1   cycles from fifo_pop high to fifo_valid high; legal 1..2
//  SKID    3   skid-buffer entries; legal >= RD_LAT+1 (full throughput needs >= RD_LAT+2)
// PORTS
//  clk          in   1      clock, all state on rising edge
//  rst_n        in   1      asynchronous active-low reset
//  fifo_pop     out  1      pop request to FIFO
//  fifo_empty   in   1      FIFO empty flag
//  fifo_valid   in   1      FIFO read data valid (RD_LAT after an accepted pop)
//  fifo_rdata   in   WIDTH  FIFO read data, sampled only when fifo_valid=1
//  flush        in   1      synchronous clear of buffered and in-flight data
//  out_valid    out  1      stream data valid
//  out_ready    in   1      consumer accepts; transfer when out_valid&&out_ready
//  out_data     out  WIDTH  stream data
//  busy         out  1      buffer non-empty or pops in flight
//  err_spurious out  1      sticky: fifo_valid seen with no pop in flight (cleared by reset only)
// BEHAVIOUR
//  - Reset: fifo_pop=0, out_valid=0, out_data=0, busy=0, err_spurious=0; count, inflight, discard, pointers = 0.
//  - State (registered): count 0..SKID, inflight 0..RD_LAT, discard 0..RD_LAT, head/tail ptrs mod SKID.
//  - fifo_pop = !fifo_empty && !flush && (count + inflight < SKID). Depends on registers and fifo_empty only;
//    no combinational path from out_ready to fifo_pop.
//  - inflight_next = inflight + fifo_pop - fifo_valid (saturation impossible by construction).
//  - fifo_valid with inflight==0: err_spurious<=1, word dropped, counters unchanged.
//  - fifo_valid with discard!=0: word dropped, discard decrements, not written to buffer.
//  - Otherwise fifo_valid writes fifo_rdata at tail; word visible on out_data next cycle (out_valid earliest
//    RD_LAT+1 cycles after pop).
//  - out_valid = (count != 0); out_data = buffer[head]; both held stable while out_valid && !out_ready.
//  - Simultaneous write and transfer: count unchanged, both pointers advance; legal at count==SKID.
//  - Pointer wrap: ptr==SKID-1 advances to 0 (SKID need not be a power of 2).
//  - Word order on out_data equals FIFO pop order; no duplication, no loss except flush/spurious.
//  - flush (any cycle): count<=0, head<=tail, fifo_pop=0 that cycle, out transfer in that cycle is ignored
//    (out_valid drops next cycle); discard <= inflight - fifo_valid(non-spurious this cycle); inflight
//    tracking continues normally so late returns are dropped. New pops resume the cycle after flush.
//  - busy = (count != 0) || (inflight != 0).
//  - Async reset mid-transfer: all state cleared immediately; in-flight FIFO returns after reset raise
//    err_spurious (system must reset FIFO and adapter together).
// STRUCTURE
//  - fifo_pkg: function ptr_w(int n) = (n<=1)?1:$clog2(n); localparam-free, shared with FIFO blocks.
//  - Sub-module pop_skid_buf #(WIDTH,SKID): register-array circular buffer, ports wr_en/wr_data/rd_en/
//    clr/count/rd_data; top holds pop, inflight, discard, error logic.
// TESTING
//  1. Reset, fifo_empty=0, out_ready=1, FIFO returns 0x0001..0x0010 -> 16 words in order, one/cycle after
//     RD_LAT+1 fill, fifo_pop high every cycle, busy falls 2 cycles after last pop's valid.
//  2. out_ready=0 with FIFO non-empty -> exactly SKID pops (3), then fifo_pop=0; out_data=first word held;
//     raise out_ready -> 3 words drained in order, pops resume same cycle count+inflight<SKID.
//  3. fifo_empty toggles every cycle, out_ready random 50% for 1000 cycles -> scoreboard order match,
//     count never > SKID, no err_spurious.
//  4. flush while inflight=1, count=2 -> next cycle out_valid=0; returning word 0xDEAD dropped; next
//     word popped after flush appears as first out_data.
//  5. fifo_valid pulse with no pop issued -> err_spurious=1 and stays 1; out_valid stays 0.
//  6. RD_LAT=2, SKID=4 rerun of 1 and 2 -> full throughput; stall after 4 pops with out_ready=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Helpers shared by the FIFO-side blocks: pointer/counter width sizing.
package fifo_pkg;

    function automatic int ptr_w(int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pop_skid_buf.sv
// Circular register-array buffer holding words returned by the FIFO until the
// downstream consumer takes them. clr discards contents by snapping head to tail.
module pop_skid_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SKID  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    input  logic                       clr,
    output logic [ptr_w(SKID+1)-1:0]   count,
    output logic [WIDTH-1:0]           rd_data
);

    localparam int PW = ptr_w(SKID);

    logic [WIDTH-1:0] mem [SKID];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    // SKID need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(SKID - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < SKID; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            count <= '0;
            head  <= tail;
        end else begin
            if (wr_en) begin
                mem[tail] <= wr_data;
                tail      <= next_ptr(tail);
            end
            if (rd_en) begin
                head <= next_ptr(head);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[head];

endmodule

// File: rtl/fifo_pop_stream.sv
// Read-side adapter: issues pops to a fixed-latency FIFO, buffers the returned
// words and presents them as a ready/valid stream with back-pressure.
module fifo_pop_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int RD_LAT = 1,
    parameter int SKID   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             fifo_pop,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_rdata,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             err_spurious
);

    localparam int CW = ptr_w(SKID + 1);
    localparam int IW = ptr_w(RD_LAT + 1);
    localparam int SW = ptr_w(SKID + RD_LAT + 1);

    logic [CW-1:0] count;
    logic [IW-1:0] inflight;
    logic [IW-1:0] inflight_nxt;
    logic [IW-1:0] discard;
    logic [IW-1:0] discard_nxt;
    logic          ret_ok;
    logic          spurious;
    logic          wr_en;
    logic          rd_en;

    always_comb begin
        spurious = fifo_valid && (inflight == '0);
        ret_ok   = fifo_valid && (inflight != '0);
        // Reserve a slot for every word in flight so the buffer can never overflow.
        fifo_pop = !fifo_empty && !flush &&
                   ((SW'(count) + SW'(inflight)) < SW'(SKID));
        wr_en    = ret_ok && (discard == '0) && !flush;
        rd_en    = out_valid && out_ready && !flush;

        inflight_nxt = inflight + IW'(fifo_pop) - IW'(ret_ok);
        discard_nxt  = discard;
        if (flush) begin
            discard_nxt = inflight - IW'(ret_ok);
        end else if (ret_ok && (discard != '0)) begin
            discard_nxt = discard - IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight     <= '0;
            discard      <= '0;
            err_spurious <= 1'b0;
        end else begin
            inflight     <= inflight_nxt;
            discard      <= discard_nxt;
            err_spurious <= err_spurious | spurious;
        end
    end

    pop_skid_buf #(
        .WIDTH (WIDTH),
        .SKID  (SKID)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (fifo_rdata),
        .rd_en   (rd_en),
        .clr     (flush),
        .count   (count),
        .rd_data (out_data)
    );

    assign out_valid = (count != '0);
    assign busy      = out_valid || (inflight != '0);

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench: channel 0 is RD_LAT=1/SKID=3, channel 1 is RD_LAT=2/SKID=4,
// each fed by a small fixed-latency FIFO model returning base+pop_index.
module tb_fifo_pop_stream;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        empty [2];
    logic        flush [2];
    logic        ready [2];
    logic        inj_v [2];
    logic [15:0] inj_d [2];
    logic [15:0] base  [2];

    wire         pop      [2];
    wire         fvalid   [2];
    wire         ovalid   [2];
    wire         busy     [2];
    wire         err      [2];
    wire  [15:0] rdata    [2];
    wire  [15:0] odata    [2];
    wire  [15:0] popcnt_w [2];

    int n_cmp  = 0;
    int n_fail = 0;

    for (genvar k = 0; k < 2; k++) begin : g_ch
        localparam int L = (k == 0) ? 1 : 2;
        localparam int S = (k == 0) ? 3 : 4;

        logic        v1, v2;
        logic [15:0] d1, d2, pc;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0; pc <= '0;
            end else begin
                v1 <= pop[k];
                if (pop[k]) begin
                    d1 <= base[k] + pc;
                    pc <= pc + 16'd1;
                end
                v2 <= v1;
                d2 <= d1;
            end
        end

        assign fvalid[k]   = ((L == 1) ? v1 : v2) | inj_v[k];
        assign rdata[k]    = inj_v[k] ? inj_d[k] : ((L == 1) ? d1 : d2);
        assign popcnt_w[k] = pc;

        fifo_pop_stream #(
            .WIDTH  (16),
            .RD_LAT (L),
            .SKID   (S)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .fifo_pop     (pop[k]),
            .fifo_empty   (empty[k]),
            .fifo_valid   (fvalid[k]),
            .fifo_rdata   (rdata[k]),
            .flush        (flush[k]),
            .out_valid    (ovalid[k]),
            .out_ready    (ready[k]),
            .out_data     (odata[k]),
            .busy         (busy[k]),
            .err_spurious (err[k])
        );
    end

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            empty[k] = 1'b1;
            flush[k] = 1'b0;
            ready[k] = 1'b0;
            inj_v[k] = 1'b0;
            inj_d[k] = 16'h0000;
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reset is asserted between edges and checked before any clock edge.
    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (pop[k] !== 1'b0) begin n_fail++; $display("FAIL reset_pop k=%0d: got %b want 0", k, pop[k]); end
            n_cmp++; if (ovalid[k] !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid k=%0d: got %b want 0", k, ovalid[k]); end
            n_cmp++; if (odata[k] !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data k=%0d: got %h want 0000", k, odata[k]); end
            n_cmp++; if (busy[k] !== 1'b0) begin n_fail++; $display("FAIL reset_busy k=%0d: got %b want 0", k, busy[k]); end
            n_cmp++; if (err[k] !== 1'b0) begin n_fail++; $display("FAIL reset_err k=%0d: got %b want 0", k, err[k]); end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // 16 words 0x0001..0x0010 streamed with the consumer always ready.
    task automatic test_stream(input int k);
        int   L;
        logic exp_v;
        logic exp_b;
        L = (k == 0) ? 1 : 2;
        do_reset();
        base[k]  = 16'h0001;
        ready[k] = 1'b1;
        for (int c = 0; c <= 18 + L; c++) begin
            empty[k] = (c >= 16);
            #1;
            exp_b = (c < 16);
            n_cmp++; if (pop[k] !== exp_b) begin n_fail++; $display("FAIL stream_pop k=%0d c=%0d: got %b want %b", k, c, pop[k], exp_b); end
            exp_v = (c >= L + 1) && (c <= 16 + L);
            n_cmp++; if (ovalid[k] !== exp_v) begin n_fail++; $display("FAIL stream_valid k=%0d c=%0d: got %b want %b", k, c, ovalid[k], exp_v); end
            if (exp_v) begin
                n_cmp++; if (odata[k] !== 16'(c - L)) begin n_fail++; $display("FAIL stream_data k=%0d c=%0d: got %h want %h", k, c, odata[k], 16'(c - L)); end
            end
            exp_b = (c >= 1) && (c <= 16 + L);
            n_cmp++; if (busy[k] !== exp_b) begin n_fail++; $display("FAIL stream_busy k=%0d c=%0d: got %b want %b", k, c, busy[k], exp_b); end
            @(negedge clk);
        end
        ready[k] = 1'b0;
        empty[k] = 1'b1;
    endtask

    // Consumer stalled: exactly SKID pops, first word held, then a gapless drain.
    task automatic test_stall(input int k);
        int   L;
        int   S;
        int   st;
        logic exp_b;
        L  = (k == 0) ? 1 : 2;
        S  = (k == 0) ? 3 : 4;
        st = S + L + 2;
        do_reset();
        base[k] = 16'h0100;
        for (int c = 0; c <= st + S + 2; c++) begin
            empty[k] = 1'b0;
            ready[k] = (c >= st);
            #1;
            if (c < st) begin
                exp_b = (c < S);
                n_cmp++; if (pop[k] !== exp_b) begin n_fail++; $display("FAIL stall_pop k=%0d c=%0d: got %b want %b", k, c, pop[k], exp_b); end
                exp_b = (c >= L + 1);
                n_cmp++; if (ovalid[k] !== exp_b) begin n_fail++; $display("FAIL stall_valid k=%0d c=%0d: got %b want %b", k, c, ovalid[k], exp_b); end
                if (exp_b) begin
                    n_cmp++; if (odata[k] !== 16'h0100) begin n_fail++; $display("FAIL stall_hold k=%0d c=%0d: got %h want 0100", k, c, odata[k]); end
                end
            end else begin
                if (c == st) begin
                    n_cmp++; if (pop[k] !== 1'b0) begin n_fail++; $display("FAIL drain_pop0 k=%0d: got %b want 0", k, pop[k]); end
                end
                if (c == st + 1) begin
                    n_cmp++; if (pop[k] !== 1'b1) begin n_fail++; $display("FAIL drain_pop1 k=%0d: got %b want 1", k, pop[k]); end
                end
                n_cmp++; if (ovalid[k] !== 1'b1) begin n_fail++; $display("FAIL drain_valid k=%0d c=%0d: got %b want 1", k, c, ovalid[k]); end
                n_cmp++; if (odata[k] !== 16'(16'h0100 + c - st)) begin n_fail++; $display("FAIL drain_data k=%0d c=%0d: got %h want %h", k, c, odata[k], 16'(16'h0100 + c - st)); end
            end
            @(negedge clk);
        end
        empty[k] = 1'b1;
        ready[k] = 1'b0;
    endtask

    // Toggling empty and random back-pressure; every delivered word must be next in sequence.
    task automatic test_random();
        int got;
        do_reset();
        base[0] = 16'h2000;
        got     = 0;
        for (int c = 0; c < 1008; c++) begin
            empty[0] = (c >= 1000) || (c % 2 == 1);
            ready[0] = (c >= 1000) ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            if (ovalid[0] && ready[0]) begin
                n_cmp++; if (odata[0] !== 16'(16'h2000 + got)) begin n_fail++; $display("FAIL random_data c=%0d: got %h want %h", c, odata[0], 16'(16'h2000 + got)); end
                got++;
            end
            @(negedge clk);
        end
        #1;
        n_cmp++; if (popcnt_w[0] !== 16'(got)) begin n_fail++; $display("FAIL random_count: delivered %0d popped %0d", got, popcnt_w[0]); end
        n_cmp++; if (got < 100) begin n_fail++; $display("FAIL random_progress: delivered %0d want >= 100", got); end
        n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL random_busy: got %b want 0", busy[0]); end
        n_cmp++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL random_err: got %b want 0", err[0]); end
        idle_inputs();
    endtask

    // Flush with count=2 and one word (0xDEAD) returning in the flush cycle.
    task automatic test_flush();
        do_reset();
        base[0] = 16'hDEAB;
        for (int c = 0; c <= 7; c++) begin
            empty[0] = !((c <= 2) || (c == 4));
            flush[0] = (c == 3);
            ready[0] = (c >= 6);
            #1;
            case (c)
                0, 1, 2: begin
                    n_cmp++; if (pop[0] !== 1'b1) begin n_fail++; $display("FAIL flush_pre_pop c=%0d: got %b want 1", c, pop[0]); end
                end
                3: begin
                    n_cmp++; if (pop[0] !== 1'b0) begin n_fail++; $display("FAIL flush_pop_block: got %b want 0", pop[0]); end
                    n_cmp++; if (odata[0] !== 16'hDEAB) begin n_fail++; $display("FAIL flush_pre_data: got %h want deab", odata[0]); end
                end
                4: begin
                    n_cmp++; if (ovalid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_valid_drop: got %b want 0", ovalid[0]); end
                    n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b want 0", busy[0]); end
                    n_cmp++; if (pop[0] !== 1'b1) begin n_fail++; $display("FAIL flush_resume_pop: got %b want 1", pop[0]); end
                end
                5: begin
                    n_cmp++; if (ovalid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_dead_dropped: got %b want 0", ovalid[0]); end
                end
                6: begin
                    n_cmp++; if (ovalid[0] !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid: got %b want 1", ovalid[0]); end
                    n_cmp++; if (odata[0] !== 16'hDEAE) begin n_fail++; $display("FAIL flush_next_data: got %h want deae", odata[0]); end
                end
                default: begin
                    n_cmp++; if (ovalid[0] !== 1'b0) begin n_fail++; $display("FAIL flush_end_valid: got %b want 0", ovalid[0]); end
                end
            endcase
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // RD_LAT=2 flush with two pops in flight: one return arrives after flush and must be discarded.
    task automatic test_flush_discard();
        do_reset();
        base[1] = 16'h3000;
        for (int c = 0; c <= 7; c++) begin
            empty[1] = (c >= 4);
            flush[1] = (c == 2);
            ready[1] = (c >= 6);
            #1;
            case (c)
                2: begin
                    n_cmp++; if (pop[1] !== 1'b0) begin n_fail++; $display("FAIL disc_pop_block: got %b want 0", pop[1]); end
                end
                3: begin
                    n_cmp++; if (pop[1] !== 1'b1) begin n_fail++; $display("FAIL disc_resume_pop: got %b want 1", pop[1]); end
                    n_cmp++; if (ovalid[1] !== 1'b0) begin n_fail++; $display("FAIL disc_valid3: got %b want 0", ovalid[1]); end
                end
                4: begin
                    n_cmp++; if (ovalid[1] !== 1'b0) begin n_fail++; $display("FAIL disc_valid4: got %b want 0", ovalid[1]); end
                    n_cmp++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL disc_busy: got %b want 1", busy[1]); end
                end
                5: begin
                    n_cmp++; if (ovalid[1] !== 1'b0) begin n_fail++; $display("FAIL disc_valid5: got %b want 0", ovalid[1]); end
                end
                6: begin
                    n_cmp++; if (ovalid[1] !== 1'b1) begin n_fail++; $display("FAIL disc_next_valid: got %b want 1", ovalid[1]); end
                    n_cmp++; if (odata[1] !== 16'h3002) begin n_fail++; $display("FAIL disc_next_data: got %h want 3002", odata[1]); end
                end
                7: begin
                    n_cmp++; if (ovalid[1] !== 1'b0) begin n_fail++; $display("FAIL disc_end_valid: got %b want 0", ovalid[1]); end
                end
                default: ;
            endcase
            @(negedge clk);
        end
        idle_inputs();
    endtask

    // fifo_valid with nothing in flight: sticky error, no data accepted.
    task automatic test_spurious();
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            inj_v[0] = (c == 1);
            inj_d[0] = 16'h1234;
            #1;
            if (c <= 1) begin
                n_cmp++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL spur_pre c=%0d: got %b want 0", c, err[0]); end
            end else begin
                n_cmp++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL spur_sticky c=%0d: got %b want 1", c, err[0]); end
                n_cmp++; if (ovalid[0] !== 1'b0) begin n_fail++; $display("FAIL spur_valid c=%0d: got %b want 0", c, ovalid[0]); end
                n_cmp++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL spur_busy c=%0d: got %b want 0", c, busy[0]); end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        base[0] = 16'h0000;
        base[1] = 16'h0000;
        test_reset();
        test_stream(0);
        test_stall(0);
        test_random();
        test_flush();
        test_spurious();
        test_reset();
        test_stream(1);
        test_stall(1);
        test_flush_discard();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
